// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: control, load and status signals of the BCD up/down counter
interface bcd_updown_counter_if #(parameter int DIGITS = 8);
    logic                  en;
    logic                  up;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  carry;
    logic                  borrow;
    logic                  load_err;
    modport master (output en, up, clear, load, load_val, input count, carry, borrow, load_err);
    modport slave  (input en, up, clear, load, load_val, output count, carry, borrow, load_err);
endinterface

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with load, clear and wrap/saturate policy
module bcd_updown_counter #(
    parameter int DIGITS    = 8,
    parameter bit EDGE_MODE = 1'b1,
    parameter bit SATURATE  = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    bcd_updown_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;
    logic [W-1:0] count_q, count_d, inc, dec;
    logic         en_q, carry_q, carry_d, borrow_q, borrow_d, load_err_q, load_err_d;
    logic         all9, all0, load_ok, step;
    assign step         = EDGE_MODE ? (bus.en & ~en_q) : bus.en;
    assign bus.count    = count_q;
    assign bus.carry    = carry_q;
    assign bus.borrow   = borrow_q;
    assign bus.load_err = load_err_q;
    // one ripple chain per direction: a digit changes only while every lower digit is at its rollover value
    always_comb begin
        inc     = count_q;
        dec     = count_q;
        all9    = 1'b1;
        all0    = 1'b1;
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (all9) inc[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
            if (all0) dec[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
            all9    = all9 & (count_q[4*i +: 4] == 4'd9);
            all0    = all0 & (count_q[4*i +: 4] == 4'd0);
            load_ok = load_ok & (bus.load_val[4*i +: 4] <= 4'd9);
        end
    end
    // clear beats load beats step; dropped actions are simply lost
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d    = load_ok ? bus.load_val : count_q;
            load_err_d = ~load_ok;
        end else if (step && bus.up) begin
            count_d = (all9 && SATURATE) ? count_q : inc;
            carry_d = all9;
        end else if (step) begin
            count_d  = (all0 && SATURATE) ? count_q : dec;
            borrow_d = all0;
        end
    end
    // count, status pulses and en history, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            en_q       <= 1'b0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            en_q       <= bus.en;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: edge, level and saturating 4-digit counters against an integer model
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(4)) e ();
    bcd_updown_counter_if #(.DIGITS(4)) l ();
    bcd_updown_counter_if #(.DIGITS(4)) s ();

    bcd_updown_counter #(.DIGITS(4), .EDGE_MODE(1'b1), .SATURATE(1'b0)) u_edge (.clk(clk), .reset(reset), .bus(e));
    bcd_updown_counter #(.DIGITS(4), .EDGE_MODE(1'b0), .SATURATE(1'b0)) u_lvl  (.clk(clk), .reset(reset), .bus(l));
    bcd_updown_counter #(.DIGITS(4), .EDGE_MODE(1'b1), .SATURATE(1'b1)) u_sat  (.clk(clk), .reset(reset), .bus(s));

    logic [15:0] cnt [3];
    logic        cry [3];
    logic        brw [3];
    logic        ler [3];
    assign cnt[0] = e.count; assign cry[0] = e.carry; assign brw[0] = e.borrow; assign ler[0] = e.load_err;
    assign cnt[1] = l.count; assign cry[1] = l.carry; assign brw[1] = l.borrow; assign ler[1] = l.load_err;
    assign cnt[2] = s.count; assign cry[2] = s.carry; assign brw[2] = s.borrow; assign ler[2] = s.load_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] x);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic bit is_bcd(input logic [15:0] x);
        bit ok = 1'b1;
        for (int i = 0; i < 4; i++) ok = ok & (x[4*i +: 4] < 4'd10);
        return ok;
    endfunction

    task automatic idle_all();
        e.en = 0; e.up = 0; e.clear = 0; e.load = 0; e.load_val = '0;
        l.en = 0; l.up = 0; l.clear = 0; l.load = 0; l.load_val = '0;
        s.en = 0; s.up = 0; s.clear = 0; s.load = 0; s.load_val = '0;
    endtask

    task automatic test_reset();
        idle_all();
        e.en = 1; e.up = 1;
        reset = 1;
        tick(); tick();
        tot_cnt++; if (e.count !== 16'h0000) $display("FAIL reset_e_count got %h want 0000", e.count); else pass_cnt++;
        tot_cnt++; if (l.count !== 16'h0000) $display("FAIL reset_l_count got %h want 0000", l.count); else pass_cnt++;
        tot_cnt++; if (s.count !== 16'h0000) $display("FAIL reset_s_count got %h want 0000", s.count); else pass_cnt++;
        tot_cnt++; if ({e.carry, e.borrow, e.load_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {e.carry, e.borrow, e.load_err}); else pass_cnt++;
        reset = 0;
    endtask

    task automatic test_edge_hold();
        repeat (10) tick();
        tot_cnt++; if (e.count !== 16'h0001) $display("FAIL edge_hold got %h want 0001", e.count); else pass_cnt++;
        repeat (12) begin
            e.en = 0; tick();
            e.en = 1; tick();
        end
        tot_cnt++; if (e.count !== 16'h0013) $display("FAIL edge_toggle got %h want 0013", e.count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        e.en = 0; e.load = 1; e.load_val = 16'h9999; tick();
        e.load = 0;
        tot_cnt++; if (e.count !== 16'h9999) $display("FAIL wrap_load got %h want 9999", e.count); else pass_cnt++;
        e.up = 1; e.en = 1; tick();
        tot_cnt++; if ({e.count, e.carry} !== {16'h0000, 1'b1}) $display("FAIL wrap_up got %h/%b want 0000/1", e.count, e.carry); else pass_cnt++;
        tick();
        tot_cnt++; if ({e.count, e.carry} !== {16'h0000, 1'b0}) $display("FAIL wrap_carry_drop got %h/%b want 0000/0", e.count, e.carry); else pass_cnt++;
        e.en = 0; tick();
        e.up = 0; e.en = 1; tick();
        tot_cnt++; if ({e.count, e.borrow} !== {16'h9999, 1'b1}) $display("FAIL wrap_down got %h/%b want 9999/1", e.count, e.borrow); else pass_cnt++;
        tick();
        tot_cnt++; if ({e.count, e.borrow} !== {16'h9999, 1'b0}) $display("FAIL wrap_borrow_drop got %h/%b want 9999/0", e.count, e.borrow); else pass_cnt++;
        e.en = 0;
    endtask

    task automatic test_saturate();
        s.load = 1; s.load_val = 16'h9999; tick();
        s.load = 0; s.up = 1;
        repeat (3) begin
            s.en = 1; tick();
            tot_cnt++; if ({s.count, s.carry} !== {16'h9999, 1'b1}) $display("FAIL sat_up got %h/%b want 9999/1", s.count, s.carry); else pass_cnt++;
            s.en = 0; tick();
            tot_cnt++; if (s.carry !== 1'b0) $display("FAIL sat_carry_drop got %b want 0", s.carry); else pass_cnt++;
        end
        s.load = 1; s.load_val = 16'h0000; tick();
        s.load = 0; s.up = 0; s.en = 1; tick();
        tot_cnt++; if ({s.count, s.borrow} !== {16'h0000, 1'b1}) $display("FAIL sat_down got %h/%b want 0000/1", s.count, s.borrow); else pass_cnt++;
        s.en = 0;
    endtask

    task automatic test_priority();
        e.en = 0; tick();
        e.clear = 1; e.load = 1; e.load_val = 16'h1234; e.en = 1; e.up = 1; tick();
        tot_cnt++; if ({e.count, e.carry} !== {16'h0000, 1'b0}) $display("FAIL prio_clear got %h/%b want 0000/0", e.count, e.carry); else pass_cnt++;
        e.clear = 0; e.load = 0; e.en = 0; tick();
        e.load = 1; e.en = 1; tick();
        tot_cnt++; if (e.count !== 16'h1234) $display("FAIL prio_load got %h want 1234", e.count); else pass_cnt++;
        e.load = 0; e.en = 0; tick();
        tot_cnt++; if (e.count !== 16'h1234) $display("FAIL prio_step_dropped got %h want 1234", e.count); else pass_cnt++;
        e.load = 1; e.load_val = 16'h12A4; tick();
        tot_cnt++; if ({e.count, e.load_err} !== {16'h1234, 1'b1}) $display("FAIL load_err got %h/%b want 1234/1", e.count, e.load_err); else pass_cnt++;
        e.load = 0; tick();
        tot_cnt++; if (e.load_err !== 1'b0) $display("FAIL load_err_drop got %b want 0", e.load_err); else pass_cnt++;
    endtask

    task automatic test_level();
        l.load = 1; l.load_val = 16'h0995; tick();
        l.load = 0; l.en = 1; l.up = 1;
        repeat (6) tick();
        tot_cnt++; if (l.count !== 16'h1001) $display("FAIL level_up got %h want 1001", l.count); else pass_cnt++;
        l.up = 0;
        repeat (2) tick();
        tot_cnt++; if (l.count !== 16'h0999) $display("FAIL level_down got %h want 0999", l.count); else pass_cnt++;
        l.en = 0;
    endtask

    task automatic test_reset_mid();
        e.en = 1; e.up = 1; tick();
        reset = 1; tick(); tick();
        tot_cnt++; if (e.count !== 16'h0000) $display("FAIL reset_mid got %h want 0000", e.count); else pass_cnt++;
        reset = 0; tick();
        tot_cnt++; if (e.count !== 16'h0001) $display("FAIL reset_release got %h want 0001", e.count); else pass_cnt++;
        tick();
        tot_cnt++; if (e.count !== 16'h0001) $display("FAIL reset_release_hold got %h want 0001", e.count); else pass_cnt++;
    endtask

    task automatic test_random();
        int          mv [3] = '{0, 0, 0};
        bit          mp [3] = '{0, 0, 0};
        bit          edge_m [3] = '{1, 0, 1};
        bit          sat_m [3] = '{0, 0, 1};
        bit          ec [3], eb [3], ee [3];
        bit          r_clear, r_load, r_en, r_up, stp;
        logic [15:0] r_val;
        idle_all();
        reset = 1; tick();
        reset = 0;
        for (int n = 0; n < 400; n++) begin
            r_clear = ($urandom_range(0, 15) == 0);
            r_load  = ($urandom_range(0, 7) == 0);
            r_en    = 1'($urandom_range(0, 1));
            r_up    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: r_val = 16'h9999;
                1: r_val = 16'h0000;
                2: r_val = to_bcd(int'($urandom_range(0, 9999)));
                default: begin
                    r_val = to_bcd(int'($urandom_range(0, 9999)));
                    r_val[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                end
            endcase
            e.clear = r_clear; e.load = r_load; e.load_val = r_val; e.en = r_en; e.up = r_up;
            l.clear = r_clear; l.load = r_load; l.load_val = r_val; l.en = r_en; l.up = r_up;
            s.clear = r_clear; s.load = r_load; s.load_val = r_val; s.en = r_en; s.up = r_up;
            for (int k = 0; k < 3; k++) begin
                stp = edge_m[k] ? (r_en && !mp[k]) : r_en;
                mp[k] = r_en;
                ec[k] = 0; eb[k] = 0; ee[k] = 0;
                if (r_clear) mv[k] = 0;
                else if (r_load) begin
                    if (is_bcd(r_val)) mv[k] = from_bcd(r_val);
                    else ee[k] = 1;
                end else if (stp && r_up) begin
                    if (mv[k] == 9999) begin ec[k] = 1; mv[k] = sat_m[k] ? 9999 : 0; end
                    else mv[k] = mv[k] + 1;
                end else if (stp) begin
                    if (mv[k] == 0) begin eb[k] = 1; mv[k] = sat_m[k] ? 0 : 9999; end
                    else mv[k] = mv[k] - 1;
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                tot_cnt++;
                if ({cnt[k], cry[k], brw[k], ler[k]} !== {to_bcd(mv[k]), ec[k], eb[k], ee[k]})
                    $display("FAIL rand dut%0d cyc%0d got %h/%b%b%b want %h/%b%b%b", k, n, cnt[k], cry[k], brw[k], ler[k], to_bcd(mv[k]), ec[k], eb[k], ee[k]);
                else pass_cnt++;
                tot_cnt++;
                if (!is_bcd(cnt[k])) $display("FAIL rand_digit dut%0d cyc%0d got %h want all digits <= 9", k, n, cnt[k]);
                else pass_cnt++;
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_edge_hold();
        test_wrap();
        test_saturate();
        test_priority();
        test_level();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
